stream_to_fsl: RTL and testbench

- Reverse-direction bridge. Takes 128-bit host stream words (s1i_*) and 160-bit ring-loopback frames, and serializes them into 5-word, 32-bit FSL frames for the processor-side FSL master port.
- Sits in the fsl_clk domain, opposite the FSL-to-stream path. It returns host data and recirculated ring traffic to the FSL consumer.
- Single clock domain; any async FIFO in front of s1i is outside this block.

---
 rtl/stream_to_fsl_pkg.sv | 37 +++
 rtl/fsl_frame_serializer.sv | 105 ++++++++++
 rtl/stream_to_fsl.sv | 143 ++++++++++++++
 tb/tb_stream_to_fsl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_to_fsl_pkg.sv
// stream_to_fsl_pkg
// Shared definitions for the host/ring to FSL return path: ring direction
// tags, FSL frame geometry, the header tag bit position, FSM and source
// enums, and the helper that formats a host word into a 5-word FSL frame.
package stream_to_fsl_pkg;

  // Ring direction tags, carried in bit 31 of a host frame header.
  localparam logic RING_DIN  = 1'b0;
  localparam logic RING_DOUT = 1'b1;

  // Every FSL frame is five 32-bit words; word 0 carries fsl_ctrl.
  localparam int          FSL_FRAME_WORDS = 5;
  localparam int          HDR_TAG_BIT     = 31;
  localparam logic [2:0]  LAST_WORD_IDX   = 3'(FSL_FRAME_WORDS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } ser_state_t;

  typedef enum logic {
    SRC_HOST,
    SRC_RING
  } src_t;

  // A host frame is a header word (tag + id) followed by the 128-bit host
  // word, most significant 32 bits first.
  function automatic logic [159:0] build_host_frame(input logic [30:0]  hdr_id,
                                                    input logic [127:0] data);
    logic [31:0] header;
    header                = '0;
    header[HDR_TAG_BIT]   = RING_DOUT;
    header[30:0]          = hdr_id;
    return {header, data};
  endfunction

endpackage

// File: rtl/fsl_frame_serializer.sv
// fsl_frame_serializer
// Takes a 160-bit frame and shifts it out as five 32-bit FSL writes, word
// bits [159:128] first, stalling while fsl_full is high.
// Ports:
//   clk, rst      FSL clock, synchronous active-high reset
//   load          capture load_data as a new frame (honoured when ready=1)
//   load_data     160-bit formatted frame
//   fsl_full      FSL FIFO full; a write is taken only when valid && !full
//   fsl_data      current FSL word
//   fsl_ctrl      high while word 0 is presented
//   fsl_valid     FSL write strobe
//   ready         a new frame may be loaded this cycle (idle, or the last
//                 word is being accepted right now)
//   active        a frame is being transmitted
module fsl_frame_serializer
  import stream_to_fsl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [159:0] load_data,
  input  logic         fsl_full,
  output logic [31:0]  fsl_data,
  output logic         fsl_ctrl,
  output logic         fsl_valid,
  output logic         ready,
  output logic         active
);

  ser_state_t   state_q, state_d;
  logic [159:0] shift_q, shift_d;
  logic [2:0]   word_cnt_q, word_cnt_d;
  logic         ctrl_q, ctrl_d;
  logic         accept;
  logic         last_word;

  assign accept    = (state_q == ST_SEND) && !fsl_full;
  assign last_word = (word_cnt_q == LAST_WORD_IDX);
  assign ready     = (state_q == ST_IDLE) || (accept && last_word);

  // The shift register is cleared whenever the serializer goes idle, so the
  // top word can drive fsl_data directly and reads zero between frames.
  assign fsl_data  = shift_q[159:128];
  assign fsl_ctrl  = ctrl_q;
  assign fsl_valid = (state_q == ST_SEND);
  assign active    = (state_q == ST_SEND);

  // State register for the serializer FSM, shift register and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      word_cnt_q <= '0;
      ctrl_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      word_cnt_q <= word_cnt_d;
      ctrl_q     <= ctrl_d;
    end
  end

  // Next-state logic. A load coinciding with acceptance of the last word
  // chains the next frame with no idle cycle in between.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    word_cnt_d = word_cnt_q;
    ctrl_d     = ctrl_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d    = ST_SEND;
          shift_d    = load_data;
          word_cnt_d = '0;
          ctrl_d     = 1'b1;
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (last_word) begin
            if (load) begin
              shift_d    = load_data;
              word_cnt_d = '0;
              ctrl_d     = 1'b1;
            end else begin
              state_d    = ST_IDLE;
              shift_d    = '0;
              word_cnt_d = '0;
              ctrl_d     = 1'b0;
            end
          end else begin
            shift_d    = {shift_q[127:0], 32'h0};
            word_cnt_d = word_cnt_q + 3'd1;
            ctrl_d     = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/stream_to_fsl.sv
// stream_to_fsl
// Returns 128-bit host stream words and 160-bit ring-loopback frames to the
// processor as 5-word FSL frames. Owns one holding register per source, the
// frame-boundary arbiter and the sticky ring overflow flag.
// Ports:
//   clk, rst        FSL clock, synchronous active-high reset
//   s1i_valid/rdy   host stream handshake, s1i_data 128-bit host word
//   ring_valid      single-cycle ring frame strobe (no backpressure)
//   ring_data       160-bit preformatted ring frame
//   fsl_data/ctrl/valid, fsl_full   FSL master port
//   ring_overflow   sticky: a ring frame arrived with nowhere to go
//   busy            frame in progress or a holding register loaded
module stream_to_fsl
  import stream_to_fsl_pkg::*;
#(
  parameter int          RING_PRIORITY = 0,
  parameter logic [30:0] HDR_ID        = 31'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s1i_valid,
  output logic         s1i_rdy,
  input  logic [127:0] s1i_data,
  input  logic [159:0] ring_data,
  input  logic         ring_valid,
  output logic [31:0]  fsl_data,
  output logic         fsl_ctrl,
  output logic         fsl_valid,
  input  logic         fsl_full,
  output logic         ring_overflow,
  output logic         busy
);

  logic         host_full_q;
  logic [127:0] host_data_q;
  logic         ring_full_q;
  logic [159:0] ring_data_q;
  src_t         last_src_q;
  logic         overflow_q;
  logic         rdy_en_q;

  logic         ser_ready;
  logic         ser_active;
  logic         frame_load;
  logic         sel_ring;
  logic         host_load;
  logic         host_free;
  logic         ring_load;
  logic         ring_free;
  logic         ring_drop;
  logic [159:0] frame_data;

  // rdy_en_q keeps s1i_rdy low during reset and for the first edge after it.
  assign s1i_rdy   = rdy_en_q && !host_full_q;
  assign host_load = s1i_valid && s1i_rdy;

  assign frame_load = (host_full_q || ring_full_q) && ser_ready;
  assign host_free  = frame_load && !sel_ring;
  assign ring_free  = frame_load && sel_ring;

  assign ring_load  = ring_valid && (!ring_full_q || ring_free);
  assign ring_drop  = ring_valid && ring_full_q && !ring_free;

  assign frame_data = sel_ring ? ring_data_q : build_host_frame(HDR_ID, host_data_q);

  assign ring_overflow = overflow_q;
  assign busy          = ser_active || host_full_q || ring_full_q;

  // Source selection. In round-robin mode a tie goes to whichever source
  // was not sent last; a lone pending source always wins.
  always_comb begin
    sel_ring = 1'b0;
    if (RING_PRIORITY != 0) begin
      sel_ring = ring_full_q;
    end else if (host_full_q && ring_full_q) begin
      sel_ring = (last_src_q == SRC_HOST);
    end else begin
      sel_ring = ring_full_q;
    end
  end

  // Host holding register. A load needs s1i_rdy (register empty), so it can
  // never coincide with the free of the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_full_q <= 1'b0;
      host_data_q <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (host_load) begin
        host_full_q <= 1'b1;
        host_data_q <= s1i_data;
      end else if (host_free) begin
        host_full_q <= 1'b0;
      end
    end
  end

  // Ring holding register and overflow flag. The ring cannot be stalled, so
  // a frame arriving while the register is occupied is lost and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_full_q <= 1'b0;
      ring_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (ring_load) begin
        ring_full_q <= 1'b1;
        ring_data_q <= ring_data;
      end else if (ring_free) begin
        ring_full_q <= 1'b0;
      end
      if (ring_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Remember the last source selected; starting at ring makes the host win
  // the first tie after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_src_q <= SRC_RING;
    end else if (frame_load) begin
      last_src_q <= sel_ring ? SRC_RING : SRC_HOST;
    end
  end

  fsl_frame_serializer u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (frame_load),
    .load_data (frame_data),
    .fsl_full  (fsl_full),
    .fsl_data  (fsl_data),
    .fsl_ctrl  (fsl_ctrl),
    .fsl_valid (fsl_valid),
    .ready     (ser_ready),
    .active    (ser_active)
  );

endmodule

// File: tb/tb_stream_to_fsl.sv
// tb_stream_to_fsl
// Directed bench for stream_to_fsl. Two instances share all inputs: dut_rr
// uses round-robin arbitration, dut_rp strict ring priority. Accepted FSL
// writes of each instance are collected into queues for frame checks.
module tb_stream_to_fsl;

  localparam logic [30:0]  HDR_ID = 31'h0ABCDEF1;
  localparam logic [31:0]  HDR    = 32'h8ABCDEF1;
  localparam logic [127:0] HOST_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] HOST_B = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
  localparam logic [159:0] RING_A = 160'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3_A4A4A4A4;
  localparam logic [159:0] RING_B = 160'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3_B4B4B4B4;

  logic         clk;
  logic         rst;
  logic         s1i_valid;
  logic [127:0] s1i_data;
  logic [159:0] ring_data;
  logic         ring_valid;
  logic         fsl_full;

  logic         rdy_a, rdy_b;
  logic [31:0]  data_a, data_b;
  logic         ctrl_a, ctrl_b;
  logic         valid_a, valid_b;
  logic         ovf_a, ovf_b;
  logic         busy_a, busy_b;

  logic [32:0]  q0[$];
  logic [32:0]  q1[$];

  int errors;
  int checks;

  logic [31:0] exp_host_a[5];
  logic [31:0] exp_host_b[5];
  logic [31:0] exp_ring_a[5];

  stream_to_fsl #(.RING_PRIORITY(0), .HDR_ID(HDR_ID)) dut_rr (
    .clk(clk), .rst(rst), .s1i_valid(s1i_valid), .s1i_rdy(rdy_a),
    .s1i_data(s1i_data), .ring_data(ring_data), .ring_valid(ring_valid),
    .fsl_data(data_a), .fsl_ctrl(ctrl_a), .fsl_valid(valid_a),
    .fsl_full(fsl_full), .ring_overflow(ovf_a), .busy(busy_a)
  );

  stream_to_fsl #(.RING_PRIORITY(1), .HDR_ID(HDR_ID)) dut_rp (
    .clk(clk), .rst(rst), .s1i_valid(s1i_valid), .s1i_rdy(rdy_b),
    .s1i_data(s1i_data), .ring_data(ring_data), .ring_valid(ring_valid),
    .fsl_data(data_b), .fsl_ctrl(ctrl_b), .fsl_valid(valid_b),
    .fsl_full(fsl_full), .ring_overflow(ovf_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted FSL write as {ctrl, data}, using pre-edge values.
  always @(posedge clk) begin
    if (!rst && valid_a && !fsl_full) q0.push_back({ctrl_a, data_a});
    if (!rst && valid_b && !fsl_full) q1.push_back({ctrl_b, data_b});
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdy: got %b, expected 0", rdy_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, expected 0", valid_a); end
    checks++; if (ctrl_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_ctrl: got %b, expected 0", ctrl_a); end
    checks++; if (data_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h, expected 0", data_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b, expected 0", ovf_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy_a); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_rdy_rise: got %b, expected 1", rdy_a); end
  endtask

  task automatic test_single_host();
    q0.delete();
    @(negedge clk);
    s1i_valid = 1'b1;
    s1i_data  = HOST_A;
    @(posedge clk);
    #1;
    checks++; if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL single_lat1_valid: got %b, expected 0", valid_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b, expected 1", busy_a); end
    @(negedge clk);
    s1i_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (valid_a !== 1'b1) begin errors++; $display("[TB] FAIL single_lat2_valid: got %b, expected 1", valid_a); end
    checks++; if (ctrl_a !== 1'b1) begin errors++; $display("[TB] FAIL single_lat2_ctrl: got %b, expected 1", ctrl_a); end
    checks++; if (data_a !== HDR) begin errors++; $display("[TB] FAIL single_lat2_data: got %h, expected %h", data_a, HDR); end
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("[TB] FAIL single_rdy_freed: got %b, expected 1", rdy_a); end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 5) begin
      errors++; $display("[TB] FAIL single_count: got %0d, expected 5", q0.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (q0[k] !== {(k == 0), exp_host_a[k]}) begin
          errors++; $display("[TB] FAIL single_word%0d: got %h, expected %h", k, q0[k], {(k == 0), exp_host_a[k]});
        end
      end
    end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy: got %b, expected 0", busy_a); end
  endtask

  task automatic test_backpressure();
    bit found;
    q0.delete();
    found = 1'b0;
    @(negedge clk);
    s1i_valid = 1'b1;
    s1i_data  = HOST_A;
    @(negedge clk);
    s1i_valid = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (q0.size() == 2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL bp_wait: got %0d words, expected 2", q0.size());
    end else begin
      fsl_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1;
        checks++; if (data_a !== exp_host_a[2]) begin errors++; $display("[TB] FAIL bp_hold_data%0d: got %h, expected %h", c, data_a, exp_host_a[2]); end
        checks++; if (valid_a !== 1'b1 || ctrl_a !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_vc%0d: got %b%b, expected 10", c, valid_a, ctrl_a); end
      end
      @(negedge clk);
      fsl_full = 1'b0;
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 5) begin
      errors++; $display("[TB] FAIL bp_count: got %0d, expected 5", q0.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (q0[k] !== {(k == 0), exp_host_a[k]}) begin
          errors++; $display("[TB] FAIL bp_word%0d: got %h, expected %h", k, q0[k], {(k == 0), exp_host_a[k]});
        end
      end
    end
  endtask

  task automatic test_ring_overflow();
    q0.delete();
    @(negedge clk);
    s1i_valid = 1'b1;
    s1i_data  = HOST_A;
    @(negedge clk);
    s1i_valid = 1'b0;
    @(negedge clk);
    ring_valid = 1'b1;
    ring_data  = RING_A;
    @(negedge clk);
    ring_data  = RING_B;
    @(negedge clk);
    ring_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 10) begin
      errors++; $display("[TB] FAIL ovf_count: got %0d, expected 10", q0.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (q0[5 + k] !== {(k == 0), exp_ring_a[k]}) begin
          errors++; $display("[TB] FAIL ovf_ring_word%0d: got %h, expected %h", k, q0[5 + k], {(k == 0), exp_ring_a[k]});
        end
      end
    end
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b, expected 1", ovf_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL ovf_idle_busy: got %b, expected 0", busy_a); end
    do_reset();
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cleared: got %b, expected 0", ovf_a); end
  endtask

  task automatic test_contention();
    do_reset();
    q0.delete();
    q1.delete();
    @(negedge clk);
    s1i_valid  = 1'b1;
    s1i_data   = HOST_A;
    ring_valid = 1'b1;
    ring_data  = RING_A;
    @(negedge clk);
    s1i_valid  = 1'b0;
    ring_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (valid_a !== 1'b1 || ctrl_a !== ((c == 0) || (c == 5))) begin
        errors++; $display("[TB] FAIL cont_rr_cycle%0d: got vc=%b%b, expected 1%b", c, valid_a, ctrl_a, (c == 0) || (c == 5));
      end
      checks++;
      if (valid_b !== 1'b1 || ctrl_b !== ((c == 0) || (c == 5))) begin
        errors++; $display("[TB] FAIL cont_rp_cycle%0d: got vc=%b%b, expected 1%b", c, valid_b, ctrl_b, (c == 0) || (c == 5));
      end
    end
    @(posedge clk);
    #1;
    checks++; if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL cont_end_valid: got %b, expected 0", valid_a); end
    checks++;
    if (q0.size() != 10 || q1.size() != 10) begin
      errors++; $display("[TB] FAIL cont_count: got %0d/%0d, expected 10/10", q0.size(), q1.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (q0[k] !== {(k == 0), exp_host_a[k]} || q0[5 + k] !== {(k == 0), exp_ring_a[k]}) begin
          errors++; $display("[TB] FAIL cont_rr_word%0d: got %h/%h, expected %h/%h", k, q0[k], q0[5 + k], {(k == 0), exp_host_a[k]}, {(k == 0), exp_ring_a[k]});
        end
        checks++;
        if (q1[k] !== {(k == 0), exp_ring_a[k]} || q1[5 + k] !== {(k == 0), exp_host_a[k]}) begin
          errors++; $display("[TB] FAIL cont_rp_word%0d: got %h/%h, expected %h/%h", k, q1[k], q1[5 + k], {(k == 0), exp_ring_a[k]}, {(k == 0), exp_host_a[k]});
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit found;
    found = 1'b0;
    q0.delete();
    @(negedge clk);
    s1i_valid = 1'b1;
    s1i_data  = HOST_A;
    @(negedge clk);
    s1i_valid = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (q0.size() == 3) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL mid_wait: got %0d words, expected 3", q0.size());
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %b, expected 0", valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b, expected 0", busy_a); end
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("[TB] FAIL mid_rdy: got %b, expected 0", rdy_a); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("[TB] FAIL mid_rdy_rise: got %b, expected 1", rdy_a); end
    q0.delete();
    @(negedge clk);
    s1i_valid = 1'b1;
    s1i_data  = HOST_B;
    @(negedge clk);
    s1i_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 5) begin
      errors++; $display("[TB] FAIL mid_count: got %0d, expected 5", q0.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (q0[k] !== {(k == 0), exp_host_b[k]}) begin
          errors++; $display("[TB] FAIL mid_word%0d: got %h, expected %h", k, q0[k], {(k == 0), exp_host_b[k]});
        end
      end
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    s1i_valid  = 1'b0;
    s1i_data   = '0;
    ring_valid = 1'b0;
    ring_data  = '0;
    fsl_full   = 1'b0;

    exp_host_a = '{HDR, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    exp_host_b = '{HDR, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98};
    exp_ring_a = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA4A4A4A4};

    $display("[TB] starting stream_to_fsl bench");
    test_reset();
    test_single_host();
    test_backpressure();
    test_ring_overflow();
    test_contention();
    test_reset_midframe();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a wait ever misbehaves.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
